// File: rtl/vx_fpu_csr_bank.sv
// vx_fpu_csr_bank: per-warp RISC-V FPU CSRs (frm, fflags, fcsr view) with an optional fflags drain interlock.
// Latency: CSR response 1 cycle after accept; read_frm is combinational from the registers.
// Backpressure: csr_req_ready drops while a response is unconsumed, or while fflags-visible FPU ops are in flight.
//
// Ports:
//   clk, reset (async, active-low)
//   read_wid -> read_frm           : frm lookup for the FPU issue path
//   write_enable/write_wid/fflags  : sticky fflags accumulation from FPU responses
//   pend_inc/pend_dec (+_wid)      : per-warp in-flight FPU op tracking; pend_full per warp
//   csr_req_* / csr_rsp_*          : valid/ready CSR instruction port, response returns the pre-op value
// Config: `define FPU_CSR_DRAIN_EN to build the in-flight counters; without it pend_* are ignored,
//   pend_full is 0 and fflags/fcsr accesses never stall.
module vx_fpu_csr_bank #(
  parameter int NUM_WARPS = 4,
  parameter int PEND_W    = 4,
  localparam int NW_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NW_W-1:0]      read_wid,
  output logic [2:0]           read_frm,
  input  logic                 write_enable,
  input  logic [NW_W-1:0]      write_wid,
  input  logic [4:0]           write_fflags,
  input  logic                 pend_inc,
  input  logic [NW_W-1:0]      pend_inc_wid,
  input  logic                 pend_dec,
  input  logic [NW_W-1:0]      pend_dec_wid,
  output logic [NUM_WARPS-1:0] pend_full,
  input  logic                 csr_req_valid,
  output logic                 csr_req_ready,
  input  logic [NW_W-1:0]      csr_req_wid,
  input  logic [11:0]          csr_req_addr,
  input  logic [1:0]           csr_req_op,
  input  logic [7:0]           csr_req_data,
  output logic                 csr_rsp_valid,
  input  logic                 csr_rsp_ready,
  output logic [7:0]           csr_rsp_data
);

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [2:0] frm_q    [NUM_WARPS];
  logic [4:0] fflags_q [NUM_WARPS];
  logic [4:0] fflags_nxt [NUM_WARPS];

  logic       rsp_vld_q;
  logic [7:0] rsp_dat_q;

  logic       hit_fflags;
  logic       hit_frm;
  logic       drain_stall;
  logic       req_fire;
  logic [7:0] csr_old;
  logic [7:0] csr_new;
  logic [2:0] frm_wr;

  assign hit_fflags = (csr_req_addr == ADDR_FFLAGS) || (csr_req_addr == ADDR_FCSR);
  assign hit_frm    = (csr_req_addr == ADDR_FRM)    || (csr_req_addr == ADDR_FCSR);

  assign csr_req_ready = (!rsp_vld_q || csr_rsp_ready) && !drain_stall;
  assign req_fire      = csr_req_valid && csr_req_ready;

  assign read_frm      = frm_q[read_wid];
  assign csr_rsp_valid = rsp_vld_q;
  assign csr_rsp_data  = rsp_dat_q;

  // Pre-op value, zero-extended; unmapped addresses read as 0.
  always_comb begin
    csr_old = '0;
    case (csr_req_addr)
      ADDR_FFLAGS: csr_old = {3'b000, fflags_q[csr_req_wid]};
      ADDR_FRM:    csr_old = {5'b00000, frm_q[csr_req_wid]};
      ADDR_FCSR:   csr_old = {frm_q[csr_req_wid], fflags_q[csr_req_wid]};
      default:     csr_old = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_old;
    case (csr_req_op)
      OP_WRITE: csr_new = csr_req_data;
      OP_SET:   csr_new = csr_old | csr_req_data;
      OP_CLEAR: csr_new = csr_old & ~csr_req_data;
      default:  csr_new = csr_old;
    endcase
  end

  // frm sits in the low bits for the frm address but in [7:5] of the fcsr view.
  assign frm_wr = (csr_req_addr == ADDR_FCSR) ? csr_new[7:5] : csr_new[2:0];

  // A CSR update and an FPU flag commit landing on the same warp merge: flags OR on top.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fflags_nxt[w] = fflags_q[w];
      if (req_fire && hit_fflags && (csr_req_wid == NW_W'(w)))
        fflags_nxt[w] = csr_new[4:0];
      if (write_enable && (write_wid == NW_W'(w)))
        fflags_nxt[w] = fflags_nxt[w] | write_fflags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        frm_q[w]    <= '0;
        fflags_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (req_fire && hit_frm && (csr_req_wid == NW_W'(w)))
          frm_q[w] <= frm_wr;
        fflags_q[w] <= fflags_nxt[w];
      end
    end
  end

  // Response register holds until consumed; no new accept can overwrite it meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
    end else if (req_fire) begin
      rsp_vld_q <= 1'b1;
      rsp_dat_q <= csr_old;
    end else if (csr_rsp_ready) begin
      rsp_vld_q <= 1'b0;
    end
  end

`ifdef FPU_CSR_DRAIN_EN
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q [NUM_WARPS];
  logic              same_wid_both;
  logic              inc_ovf;
  logic              dec_unf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (pend_inc && (pend_inc_wid == NW_W'(w)) &&
            !(pend_dec && (pend_dec_wid == NW_W'(w)))) begin
          if (cnt_q[w] != CNT_MAX) cnt_q[w] <= cnt_q[w] + PEND_W'(1);
        end else if (pend_dec && (pend_dec_wid == NW_W'(w)) &&
                     !(pend_inc && (pend_inc_wid == NW_W'(w)))) begin
          if (cnt_q[w] != '0) cnt_q[w] <= cnt_q[w] - PEND_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) pend_full[w] = (cnt_q[w] == CNT_MAX);
  end

  // fflags must not be observed while ops that may still raise flags are in flight.
  assign drain_stall = hit_fflags && (cnt_q[csr_req_wid] != '0);

  assign same_wid_both = pend_inc && pend_dec && (pend_inc_wid == pend_dec_wid);
  assign inc_ovf = pend_inc && !same_wid_both && (cnt_q[pend_inc_wid] == CNT_MAX);
  assign dec_unf = pend_dec && !same_wid_both && (cnt_q[pend_dec_wid] == '0);

  a_pend_inc_ovf: assert property (@(posedge clk) disable iff (!reset) !inc_ovf);
  a_pend_dec_unf: assert property (@(posedge clk) disable iff (!reset) !dec_unf);
`else
  logic unused_pend;
  assign unused_pend = ^{pend_inc, pend_inc_wid, pend_dec, pend_dec_wid};
  assign pend_full   = '0;
  assign drain_stall = 1'b0;
`endif

endmodule

// File: tb/tb_vx_fpu_csr_bank.sv
// tb_vx_fpu_csr_bank: randomized and directed checks of vx_fpu_csr_bank against a per-warp fcsr model.
// Latency: expects responses one cycle after accept.
// Backpressure: exercises held responses and (when built with FPU_CSR_DRAIN_EN) drain stalls.
module tb_vx_fpu_csr_bank;
  localparam int NW     = 4;
  localparam int NW_W   = 2;
  localparam int PEND_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NW_W-1:0] read_wid;
  logic [2:0]      read_frm;
  logic            write_enable;
  logic [NW_W-1:0] write_wid;
  logic [4:0]      write_fflags;
  logic            pend_inc;
  logic [NW_W-1:0] pend_inc_wid;
  logic            pend_dec;
  logic [NW_W-1:0] pend_dec_wid;
  logic [NW-1:0]   pend_full;
  logic            csr_req_valid;
  logic            csr_req_ready;
  logic [NW_W-1:0] csr_req_wid;
  logic [11:0]     csr_req_addr;
  logic [1:0]      csr_req_op;
  logic [7:0]      csr_req_data;
  logic            csr_rsp_valid;
  logic            csr_rsp_ready;
  logic [7:0]      csr_rsp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: one 8-bit fcsr per warp; fflags = low 5 bits, frm = high 3 bits.
  int m_fcsr [NW];

  vx_fpu_csr_bank #(.NUM_WARPS(NW), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset),
    .read_wid(read_wid), .read_frm(read_frm),
    .write_enable(write_enable), .write_wid(write_wid), .write_fflags(write_fflags),
    .pend_inc(pend_inc), .pend_inc_wid(pend_inc_wid),
    .pend_dec(pend_dec), .pend_dec_wid(pend_dec_wid), .pend_full(pend_full),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_req_wid(csr_req_wid), .csr_req_addr(csr_req_addr),
    .csr_req_op(csr_req_op), .csr_req_data(csr_req_data),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready), .csr_rsp_data(csr_rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_access(int wid, int addr, int op, int data);
    int shift, mask, old, nv;
    case (addr)
      1:       begin shift = 0; mask = 31;  end
      2:       begin shift = 5; mask = 7;   end
      3:       begin shift = 0; mask = 255; end
      default: return 8'h00;
    endcase
    old = (m_fcsr[wid] >> shift) & mask;
    case (op)
      0:       nv = old;
      1:       nv = data;
      2:       nv = old | data;
      default: nv = old & ~data;
    endcase
    nv = nv & mask;
    m_fcsr[wid] = (m_fcsr[wid] & ~(mask << shift)) | (nv << shift);
    return 8'(old);
  endfunction

  function automatic void model_flags(int wid, int f);
    m_fcsr[wid] = m_fcsr[wid] | (f & 31);
  endfunction

  function automatic int model_frm(int wid);
    return (m_fcsr[wid] >> 5) & 7;
  endfunction

  // Called just after a falling edge; returns just after the following falling edge.
  task automatic do_req(input int wid, input int addr, input int op, input int data,
                        output logic [7:0] rsp, output bit got_vld);
    int cyc;
    csr_req_valid = 1'b1;
    csr_req_wid   = NW_W'(wid);
    csr_req_addr  = 12'(addr);
    csr_req_op    = 2'(op);
    csr_req_data  = 8'(data);
    #1;
    cyc = 0;
    while (!csr_req_ready && cyc < 64) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (!csr_req_ready) begin
      csr_req_valid = 1'b0;
      rsp = 8'h00;
      got_vld = 1'b0;
      return;
    end
    @(posedge clk); #1;
    csr_req_valid = 1'b0;
    @(negedge clk);
    rsp = csr_rsp_data;
    got_vld = csr_rsp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    read_wid = '0; write_enable = 0; write_wid = '0; write_fflags = '0;
    pend_inc = 0; pend_inc_wid = '0; pend_dec = 0; pend_dec_wid = '0;
    csr_req_valid = 0; csr_req_wid = '0; csr_req_addr = '0; csr_req_op = '0; csr_req_data = '0;
    csr_rsp_ready = 1'b1;
    for (int w = 0; w < NW; w++) m_fcsr[w] = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (csr_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", csr_rsp_valid); end
    n_cmp++; if (csr_rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", csr_rsp_data); end
    n_cmp++; if (pend_full !== '0) begin n_fail++; $display("FAIL reset_pend_full: got %b want 0", pend_full); end
    n_cmp++; if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", csr_req_ready); end
    for (int w = 0; w < NW; w++) begin
      read_wid = NW_W'(w); #1;
      n_cmp++; if (read_frm !== 3'd0) begin n_fail++; $display("FAIL reset_frm w%0d: got %0d want 0", w, read_frm); end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_frm_write();
    logic [7:0] got, exp; bit v;
    exp = model_access(1, 2, 1, 3);
    do_req(1, 2, 1, 3, got, v);
    n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL frm_write_rsp: got v=%b %h want %h", v, got, exp); end
    read_wid = 2'd1; #1;
    n_cmp++; if (read_frm !== 3'(model_frm(1))) begin n_fail++; $display("FAIL frm_w1: got %0d want %0d", read_frm, model_frm(1)); end
    read_wid = 2'd0; #1;
    n_cmp++; if (read_frm !== 3'(model_frm(0))) begin n_fail++; $display("FAIL frm_w0: got %0d want %0d", read_frm, model_frm(0)); end
  endtask

  task automatic test_fflags_accum();
    logic [7:0] got, exp; bit v;
    write_enable = 1'b1; write_wid = 2'd2; write_fflags = 5'h01; model_flags(2, 1);
    @(negedge clk);
    write_fflags = 5'h04; model_flags(2, 4);
    @(negedge clk);
    write_enable = 1'b0;
    exp = model_access(2, 3, 0, 0);
    do_req(2, 3, 0, 0, got, v);
    n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL fflags_accum: got v=%b %h want %h", v, got, exp); end
  endtask

  task automatic test_set_clear();
    logic [7:0] got, exp; bit v;
    int ops [3] = '{2, 3, 0};
    int dat [3] = '{31, 3, 0};
    for (int i = 0; i < 3; i++) begin
      exp = model_access(3, 1, ops[i], dat[i]);
      do_req(3, 1, ops[i], dat[i], got, v);
      n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL set_clear step%0d: got v=%b %h want %h", i, v, got, exp); end
    end
  endtask

  task automatic test_frm_raw();
    logic [7:0] got, exp; bit v;
    for (int f = 5; f < 8; f++) begin
      exp = model_access(0, 2, 1, f);
      do_req(0, 2, 1, f, got, v);
      read_wid = 2'd0; #1;
      n_cmp++; if (read_frm !== 3'(model_frm(0))) begin n_fail++; $display("FAIL frm_raw %0d: got %0d want %0d", f, read_frm, model_frm(0)); end
    end
    exp = model_access(1, 3, 1, 8'hE3);
    do_req(1, 3, 1, 8'hE3, got, v);
    exp = model_access(1, 3, 0, 0);
    do_req(1, 3, 0, 0, got, v);
    n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL fcsr_raw: got v=%b %h want %h", v, got, exp); end
  endtask

  task automatic test_unmapped();
    logic [7:0] got, exp; bit v;
    int addrs [3] = '{0, 4, 12'hFFF};
    for (int i = 0; i < 3; i++) begin
      exp = model_access(i, addrs[i], 1, 8'hFF);
      do_req(i, addrs[i], 1, 8'hFF, got, v);
      n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL unmapped %h: got v=%b %h want %h", addrs[i], v, got, exp); end
    end
    for (int w = 0; w < NW; w++) begin
      exp = model_access(w, 3, 0, 0);
      do_req(w, 3, 0, 0, got, v);
      n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL unmapped_keep w%0d: got %h want %h", w, got, exp); end
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] got, exp; bit v;
    csr_req_valid = 1'b1; csr_req_wid = 2'd2; csr_req_addr = 12'h001; csr_req_op = 2'b01; csr_req_data = 8'h10;
    write_enable = 1'b1; write_wid = 2'd2; write_fflags = 5'h02;
    exp = model_access(2, 1, 1, 8'h10);
    model_flags(2, 2);
    #1;
    n_cmp++; if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_ready: got %b want 1", csr_req_ready); end
    @(posedge clk); #1;
    csr_req_valid = 1'b0; write_enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (csr_rsp_valid !== 1'b1 || csr_rsp_data !== exp) begin n_fail++; $display("FAIL same_cycle_rsp: got v=%b %h want %h", csr_rsp_valid, csr_rsp_data, exp); end
    exp = model_access(2, 1, 0, 0);
    do_req(2, 1, 0, 0, got, v);
    n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL same_cycle_merge: got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    bit prev_vld = 0;
    logic [7:0] prev_exp = '0;
    int prev_rw = 0;
    int k, a, w, op, d, wf;
    bit v, we;
    @(negedge clk);
    for (int i = 0; i <= 300; i++) begin
      if (i > 0) begin
        n_cmp++; if (csr_rsp_valid !== prev_vld) begin n_fail++; $display("FAIL b2b_vld i%0d: got %b want %b", i, csr_rsp_valid, prev_vld); end
        if (prev_vld) begin
          n_cmp++; if (csr_rsp_data !== prev_exp) begin n_fail++; $display("FAIL b2b_data i%0d: got %h want %h", i, csr_rsp_data, prev_exp); end
        end
        n_cmp++; if (read_frm !== 3'(model_frm(prev_rw))) begin n_fail++; $display("FAIL b2b_frm i%0d: got %0d want %0d", i, read_frm, model_frm(prev_rw)); end
      end
      if (i == 300) break;
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) == 0);
      k  = $urandom_range(0, 4);
      a  = (k == 0) ? 1 : (k == 1) ? 2 : (k <= 3) ? 3 : $urandom_range(4, 4095);
      w  = $urandom_range(0, NW - 1);
      op = $urandom_range(0, 3);
      d  = $urandom_range(0, 255);
      wf = $urandom_range(0, 31);
      csr_req_valid = v; csr_req_wid = NW_W'(w); csr_req_addr = 12'(a);
      csr_req_op = 2'(op); csr_req_data = 8'(d);
      write_enable = we; write_wid = NW_W'($urandom_range(0, NW - 1)); write_fflags = 5'(wf);
      prev_rw = $urandom_range(0, NW - 1);
      read_wid = NW_W'(prev_rw);
      if (v) prev_exp = model_access(w, a, op, d);
      if (we) model_flags(int'(write_wid), wf);
      prev_vld = v;
      #1;
      n_cmp++; if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i%0d: got %b want 1", i, csr_req_ready); end
      @(negedge clk);
    end
    csr_req_valid = 1'b0; write_enable = 1'b0;
  endtask

`ifdef FPU_CSR_DRAIN_EN
  task automatic test_drain();
    logic [7:0] exp;
    pend_inc = 1'b1; pend_inc_wid = 2'd0;
    @(negedge clk); @(negedge clk);
    pend_inc = 1'b0;
    csr_req_valid = 1'b1; csr_req_wid = 2'd0; csr_req_addr = 12'h001; csr_req_op = 2'b00; csr_req_data = 8'h00;
    #1;
    n_cmp++; if (pend_full !== 4'b0000) begin n_fail++; $display("FAIL drain_full2: got %b want 0000", pend_full); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (csr_req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_stall c%0d: got %b want 0", c, csr_req_ready); end
      @(negedge clk); #1;
    end
    pend_dec = 1'b1; pend_dec_wid = 2'd0;
    @(negedge clk); #1;
    n_cmp++; if (csr_req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_one_left: got %b want 0", csr_req_ready); end
    @(negedge clk);
    pend_dec = 1'b0;
    #1;
    n_cmp++; if (csr_req_ready !== 1'b1 || csr_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_release: got rdy=%b vld=%b want 1/0", csr_req_ready, csr_rsp_valid); end
    exp = model_access(0, 1, 0, 0);
    @(posedge clk); #1;
    csr_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (csr_rsp_valid !== 1'b1 || csr_rsp_data !== exp) begin n_fail++; $display("FAIL drain_rsp: got v=%b %h want %h", csr_rsp_valid, csr_rsp_data, exp); end
    pend_inc = 1'b1; pend_inc_wid = 2'd1;
    repeat (15) @(negedge clk);
    pend_inc = 1'b0;
    #1;
    n_cmp++; if (pend_full !== 4'b0010) begin n_fail++; $display("FAIL pend_full_w1: got %b want 0010", pend_full); end
    csr_req_valid = 1'b1; csr_req_wid = 2'd1; csr_req_addr = 12'h002; #1;
    n_cmp++; if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL frm_no_stall: got %b want 1", csr_req_ready); end
    csr_req_addr = 12'h003; #1;
    n_cmp++; if (csr_req_ready !== 1'b0) begin n_fail++; $display("FAIL fcsr_stall: got %b want 0", csr_req_ready); end
    csr_req_valid = 1'b0;
    pend_inc = 1'b1; pend_dec = 1'b1; pend_dec_wid = 2'd1;
    @(negedge clk);
    pend_inc = 1'b0;
    #1;
    n_cmp++; if (pend_full !== 4'b0010) begin n_fail++; $display("FAIL inc_dec_same: got %b want 0010", pend_full); end
    repeat (15) @(negedge clk);
    pend_dec = 1'b0;
    #1;
    n_cmp++; if (pend_full !== 4'b0000) begin n_fail++; $display("FAIL pend_drained: got %b want 0000", pend_full); end
    @(negedge clk);
  endtask
`else
  task automatic test_drain();
    logic [7:0] exp;
    pend_inc = 1'b1; pend_inc_wid = 2'd0;
    @(negedge clk);
    pend_inc = 1'b0;
    csr_req_valid = 1'b1; csr_req_wid = 2'd0; csr_req_addr = 12'h001; csr_req_op = 2'b00; csr_req_data = 8'h00;
    #1;
    n_cmp++; if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL nodrain_ready: got %b want 1", csr_req_ready); end
    n_cmp++; if (pend_full !== 4'b0000) begin n_fail++; $display("FAIL nodrain_full: got %b want 0000", pend_full); end
    exp = model_access(0, 1, 0, 0);
    @(posedge clk); #1;
    csr_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (csr_rsp_valid !== 1'b1 || csr_rsp_data !== exp) begin n_fail++; $display("FAIL nodrain_rsp: got v=%b %h want %h", csr_rsp_valid, csr_rsp_data, exp); end
  endtask
`endif

  task automatic test_stall_reset();
    logic [7:0] got, exp; bit v;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    exp = model_access(1, 3, 1, 8'hA5);
    do_req(1, 3, 1, 8'hA5, got, v);
    n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL stall_first: got v=%b %h want %h", v, got, exp); end
    csr_req_valid = 1'b1; csr_req_wid = 2'd0; csr_req_addr = 12'h001; csr_req_op = 2'b01; csr_req_data = 8'h1F;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (csr_rsp_valid !== 1'b1 || csr_rsp_data !== exp || csr_req_ready !== 1'b0)
        begin n_fail++; $display("FAIL stall_hold c%0d: got v=%b %h rdy=%b want 1 %h 0", c, csr_rsp_valid, csr_rsp_data, csr_req_ready, exp); end
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (csr_rsp_valid !== 1'b0 || csr_rsp_data !== 8'h00) begin n_fail++; $display("FAIL stall_reset_rsp: got v=%b %h want 0 00", csr_rsp_valid, csr_rsp_data); end
    for (int w = 0; w < NW; w++) begin
      read_wid = NW_W'(w); #1;
      n_cmp++; if (read_frm !== 3'd0) begin n_fail++; $display("FAIL stall_reset_frm w%0d: got %0d want 0", w, read_frm); end
    end
    @(negedge clk);
    csr_req_valid = 1'b0; csr_rsp_ready = 1'b1; reset = 1'b1;
    for (int w = 0; w < NW; w++) m_fcsr[w] = 0;
    for (int i = 0; i < NW; i++) begin
      int w = (i + 1) % NW;
      exp = model_access(w, 3, 0, 0);
      do_req(w, 3, 0, 0, got, v);
      n_cmp++; if (!v || got !== exp) begin n_fail++; $display("FAIL post_reset w%0d: got v=%b %h want %h", w, v, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_frm_write();
    test_fflags_accum();
    test_set_clear();
    test_frm_raw();
    test_unmapped();
    test_same_cycle();
    test_drain();
    test_back_to_back();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
